// File: rtl/alu_pkg.sv
// Shared opcode constants for the ALU decoder and its testbenches.
package alu_pkg;

    localparam int unsigned DataWidth = 32;

    localparam logic [4:0] OpAdd   = 5'b00000;
    localparam logic [4:0] OpSub   = 5'b00001;
    localparam logic [4:0] OpSll   = 5'b00010;
    localparam logic [4:0] OpSlt   = 5'b00011;
    localparam logic [4:0] OpSltu  = 5'b00100;
    localparam logic [4:0] OpXor   = 5'b00101;
    localparam logic [4:0] OpSrl   = 5'b00110;
    localparam logic [4:0] OpSra   = 5'b00111;
    localparam logic [4:0] OpOr    = 5'b01000;
    localparam logic [4:0] OpAnd   = 5'b01001;
    localparam logic [4:0] OpPassB = 5'b01010;
    localparam logic [4:0] OpEq    = 5'b01011;
    localparam logic [4:0] OpNe    = 5'b01100;
    localparam logic [4:0] OpLt    = 5'b01101;
    localparam logic [4:0] OpGe    = 5'b01110;
    localparam logic [4:0] OpLtu   = 5'b01111;
    localparam logic [4:0] OpGeu   = 5'b10000;

endpackage

// File: rtl/alu_compare.sv
// Comparison primitives (equal, signed less-than, unsigned less-than)
// from which every ALU compare operation is derived.
module alu_compare
    import alu_pkg::*;
(
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    output logic                 eq_o,
    output logic                 lt_o,
    output logic                 ltu_o
);

    assign eq_o  = (a_i == b_i);
    assign lt_o  = ($signed(a_i) < $signed(b_i));
    assign ltu_o = (a_i < b_i);

endmodule

// File: rtl/main_alu.sv
// Single-cycle ALU: combinational operation mux feeding registered
// result and compare-flag outputs.
module main_alu
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Control,
    input  logic [DataWidth-1:0] A,
    input  logic [DataWidth-1:0] B,
    output logic [DataWidth-1:0] ALU_out,
    output logic                 Flag
);

    logic                 eq, lt, ltu;
    logic [4:0]           shamt;
    logic [DataWidth-1:0] result_d, result_q;
    logic                 flag_d, flag_q;
    logic                 is_cmp;

    alu_compare u_compare (
        .a_i   (A),
        .b_i   (B),
        .eq_o  (eq),
        .lt_o  (lt),
        .ltu_o (ltu)
    );

    assign shamt = B[4:0];

    always_comb begin
        result_d = '0;
        flag_d   = 1'b0;
        is_cmp   = 1'b0;
        case (Control)
            OpAdd:   result_d = A + B;
            OpSub:   result_d = A - B;
            OpSll:   result_d = A << shamt;
            OpSrl:   result_d = A >> shamt;
            OpSra:   result_d = $unsigned($signed(A) >>> shamt);
            OpXor:   result_d = A ^ B;
            OpOr:    result_d = A | B;
            OpAnd:   result_d = A & B;
            OpPassB: result_d = B;
            OpSlt, OpLt: begin
                is_cmp = 1'b1;
                flag_d = lt;
            end
            OpSltu, OpLtu: begin
                is_cmp = 1'b1;
                flag_d = ltu;
            end
            OpEq: begin
                is_cmp = 1'b1;
                flag_d = eq;
            end
            OpNe: begin
                is_cmp = 1'b1;
                flag_d = ~eq;
            end
            OpGe: begin
                is_cmp = 1'b1;
                flag_d = ~lt;
            end
            OpGeu: begin
                is_cmp = 1'b1;
                flag_d = ~ltu;
            end
            default: ;
        endcase
        // Compare ops report the flag in the LSB of the result as well.
        if (is_cmp) begin
            result_d = {{(DataWidth-1){1'b0}}, flag_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign ALU_out = result_q;
    assign Flag    = flag_q;

endmodule

// File: tb/tb_main_alu.sv
// Directed-vector testbench for main_alu with hand-computed expectations.
module tb_main_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  Control;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALU_out;
    logic        Flag;

    int unsigned n_cmp;
    int unsigned n_err;

    main_alu dut (
        .clk     (clk),
        .rst     (rst),
        .Control (Control),
        .A       (A),
        .B       (B),
        .ALU_out (ALU_out),
        .Flag    (Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one operation, let one edge pass, then check both outputs.
    task automatic apply(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_out, input logic exp_flag);
        Control = op;
        A       = a;
        B       = b;
        @(posedge clk);
        #1;
        check_eq({tag, ".out"}, ALU_out, exp_out);
        check_eq({tag, ".flag"}, {31'b0, Flag}, {31'b0, exp_flag});
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        Control = OpAdd;
        A       = 32'h1234_5678;
        B       = 32'h1111_1111;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.out", ALU_out, 32'h0);
        check_eq("reset.flag", {31'b0, Flag}, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("release.hold", ALU_out, 32'h0);

        apply("add0",  OpAdd,  32'hFFFF_FFF3, 32'h0000_000A, 32'hFFFF_FFFD, 1'b0);
        apply("add1",  OpAdd,  32'd10,        32'd15,        32'h0000_0019, 1'b0);
        apply("addwr", OpAdd,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0);
        apply("sub0",  OpSub,  32'hFFFF_FFF3, 32'hFFFF_FFF5, 32'hFFFF_FFFE, 1'b0);
        apply("sub1",  OpSub,  32'd25,        32'hFFFF_FFF3, 32'h0000_0026, 1'b0);
        apply("sll",   OpSll,  32'hB38F_0F83, 32'd4,         32'h38F0_F830, 1'b0);
        apply("srl",   OpSrl,  32'hB38F_0F83, 32'd4,         32'h0B38_F0F8, 1'b0);
        apply("sra",   OpSra,  32'hB38F_0F83, 32'd4,         32'hFB38_F0F8, 1'b0);
        apply("sllhi", OpSll,  32'hB38F_0F83, 32'hFFFF_FFE4, 32'h38F0_F830, 1'b0);
        apply("sra0",  OpSra,  32'hB38F_0F83, 32'h0000_0020, 32'hB38F_0F83, 1'b0);
        apply("srapos",OpSra,  32'h7000_0000, 32'd31,        32'h0000_0000, 1'b0);
        apply("slt",   OpSlt,  32'hFFFF_FFF3, 32'd4,         32'h0000_0001, 1'b1);
        apply("sltu",  OpSltu, 32'hFFFF_FFF3, 32'd4,         32'h0000_0000, 1'b0);
        apply("ltu",   OpLtu,  32'd4,         32'hFFFF_FFF3, 32'h0000_0001, 1'b1);
        apply("ge",    OpGe,   32'h0000_0400, 32'hFFFF_F7F7, 32'h0000_0001, 1'b1);
        apply("geu",   OpGeu,  32'h0000_0400, 32'hFFFF_F7F7, 32'h0000_0000, 1'b0);
        apply("lt",    OpLt,   32'h0000_0400, 32'hFFFF_F7F7, 32'h0000_0000, 1'b0);
        apply("geeq",  OpGe,   32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b1);
        apply("eq",    OpEq,   32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0001, 1'b1);
        apply("ne",    OpNe,   32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0);
        apply("ne1",   OpNe,   32'd1,         32'd2,         32'h0000_0001, 1'b1);
        apply("xor",   OpXor,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1'b0);
        apply("or",    OpOr,   32'hAAAA_AAAA, 32'hFFFF_0000, 32'hFFFF_AAAA, 1'b0);
        apply("and",   OpAnd,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'hAAAA_0000, 1'b0);
        apply("passb", OpPassB,32'hAAAA_AAAA, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0);
        apply("ill15", 5'b10101, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h0000_0000, 1'b0);
        apply("ill31", 5'b11111, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0);

        // Mid-stream asynchronous reset while output is nonzero.
        apply("pre_rst", OpEq, 32'h5, 32'h5, 32'h0000_0001, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst.out", ALU_out, 32'h0);
        check_eq("async_rst.flag", {31'b0, Flag}, 32'h0);
        Control = OpAdd;
        A       = 32'd10;
        B       = 32'd15;
        #1 rst = 1'b0;
        #1;
        check_eq("post_rst.hold", ALU_out, 32'h0);
        @(posedge clk);
        #1;
        check_eq("post_rst.first", ALU_out, 32'h0000_0019);
        check_eq("post_rst.flag", {31'b0, Flag}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
